// File: rtl/pipeline_id_hazard.sv
// ID-stage hazard unit: detects load-use and branch-operand hazards,
// stalls the PC and IF/ID register, inserts ID/EX bubbles, and owns the
// IF/ID pipeline register including taken-branch / interrupt flushes.
module pipeline_id_hazard #(
  parameter int unsigned DW       = 32,
  parameter int unsigned LB_STALL = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] if_pc,
  input  logic [DW-1:0] if_instr,
  input  logic          ex_regwr,
  input  logic          ex_memrd,
  input  logic [4:0]    ex_wrreg,
  input  logic          mem_memrd,
  input  logic [4:0]    mem_wrreg,
  input  logic          id_branch,
  input  logic          id_taken,
  input  logic          irq,
  output logic [DW-1:0] id_pc,
  output logic [DW-1:0] id_instr,
  output logic          id_valid,
  output logic          pc_en,
  output logic          bubble,
  output logic [31:0]   stall_cnt
);

  localparam int unsigned CW  = 3;
  localparam int unsigned RW  = 5;
  localparam int unsigned SCW = 32;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] hz_n;
  logic [RW-1:0] rs, rt;
  logic          ex_hit, mem_hit;
  logic          flush;

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic [RW-1:0] dst,
                                   input logic [RW-1:0] a,
                                   input logic [RW-1:0] b);
    return (dst != RW'(0)) && ((dst == a) || (dst == b));
  endfunction

  assign ex_hit  = src_hit(ex_wrreg, rs, rt);
  assign mem_hit = src_hit(mem_wrreg, rs, rt);

  // Hazard length, only meaningful for a real instruction while running.
  always_comb begin
    hz_n = '0;
    if (state == RUN && id_valid) begin
      if (id_branch && ex_regwr && ex_memrd && ex_hit) hz_n = CW'(LB_STALL);
      else if (id_branch && ex_regwr && ex_hit)        hz_n = CW'(1);
      else if (id_branch && mem_memrd && mem_hit)      hz_n = CW'(1);
      else if (!id_branch && ex_memrd && ex_hit)       hz_n = CW'(1);
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stall FSM next-state and pipeline control; first stall cycle is spent in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_en     = 1'b1;
    bubble    = 1'b0;
    case (state)
      RUN: begin
        if (hz_n != '0) begin
          pc_en  = 1'b0;
          bubble = 1'b1;
          if (hz_n >= CW'(2)) begin
            state_nxt = STALL;
            cnt_nxt   = hz_n - CW'(1);
          end
        end
      end
      STALL: begin
        pc_en   = 1'b0;
        bubble  = 1'b1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // A held register cannot flush; the flush is picked up once pc_en returns.
  assign flush = pc_en & ((id_valid & id_taken) | irq);

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_pc    <= '0;
      id_instr <= '0;
      id_valid <= 1'b0;
    end else if (pc_en) begin
      id_pc <= if_pc;
      if (flush) begin
        id_instr <= '0;
        id_valid <= 1'b0;
      end else begin
        id_instr <= if_instr;
        id_valid <= 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {SCW{1'b1}})) begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end

endmodule
